// File: rtl/divider_feeder.sv
// Request FIFO and launch/capture sequencer that feeds one shared iterative
// divider, returning tagged results in request order over a valid/ready port.
module divider_feeder #(
    parameter int BIT_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 div_en,
    output logic [BIT_WIDTH-1:0] div_a,
    output logic [BIT_WIDTH-1:0] div_b,
    input  logic                 div_flag,
    input  logic [BIT_WIDTH:0]   div_q,
    input  logic [BIT_WIDTH-1:0] div_r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH:0]   out_q,
    output logic [BIT_WIDTH-1:0] out_r,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_dz,
    output logic                 busy,
    output logic [1:0]           fsm_state
);
    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; valid, once raised, holds its payload until then.

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * BIT_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_nonempty;
    logic                 push;
    logic                 pop;
    logic [BIT_WIDTH-1:0] head_a;
    logic [BIT_WIDTH-1:0] head_b;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [TAG_WIDTH-1:0] tag_r;
    logic                 dz_r;

    assign fsm_state     = state;
    assign fifo_nonempty = (count != '0);
    // in_ready looks only at the registered count, so a full FIFO never
    // accepts even when the head is being popped on the same edge.
    assign in_ready      = n_rst && (count < CNT_W'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;
    assign pop           = fifo_nonempty &&
                           ((state == IDLE) || ((state == HOLD) && out_ready));
    assign busy          = n_rst && (fifo_nonempty || (state != IDLE));
    assign {head_a, head_b, head_tag} = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_tag};
        end
    end

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state     <= IDLE;
            div_en    <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            tag_r     <= '0;
            dz_r      <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_tag   <= '0;
            out_dz    <= 1'b0;
        end else begin
            // A pop always loads the head and starts a division next cycle.
            if (pop) begin
                div_a  <= head_a;
                div_b  <= head_b;
                tag_r  <= head_tag;
                dz_r   <= (head_b == '0);
                div_en <= 1'b1;
                state  <= LAUNCH;
            end
            case (state)
                IDLE: ;
                LAUNCH: begin
                    div_en <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // The divider clears its flag when it samples div_en, so any
                    // flag seen here belongs to the current operation.
                    if (div_flag) begin
                        out_q     <= div_q;
                        out_r     <= div_r;
                        out_tag   <= tag_r;
                        out_dz    <= dz_r;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_nonempty) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_feeder.sv
// Directed bench for divider_feeder with a behavioural iterative divider
// attached; results are matched against a hand-computed expected queue.
module tb_divider_feeder;
    localparam int BW = 8;
    localparam int TW = 4;
    localparam int EW = (BW + 1) + BW + TW + 1;

    logic          clock;
    logic          n_rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          div_en;
    logic [BW-1:0] div_a;
    logic [BW-1:0] div_b;
    logic          div_flag;
    logic [BW:0]   div_q;
    logic [BW-1:0] div_r;
    logic          out_valid;
    logic          out_ready;
    logic [BW:0]   out_q;
    logic [BW-1:0] out_r;
    logic [TW-1:0] out_tag;
    logic          out_dz;
    logic          busy;
    logic [1:0]    fsm_state;

    divider_feeder #(.BIT_WIDTH(BW), .TAG_WIDTH(TW), .FIFO_DEPTH(4)) dut (
        .clock(clock), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_en(div_en), .div_a(div_a), .div_b(div_b),
        .div_flag(div_flag), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_tag(out_tag), .out_dz(out_dz),
        .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    int cyc = 0;
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- divider model: flag rises BW+2 cycles after div_en ----------------
    logic [3:0] dcnt;

    function automatic logic [2*BW:0] div_model(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [BW:0] sa, sb, sq, sr;
        sa = {a[BW-1], a};
        sb = {b[BW-1], b};
        if (b == '0) return {{(BW+1){1'b0}}, a};
        sq = sa / sb;
        sr = sa % sb;
        return {sq, sr[BW-1:0]};
    endfunction

    always @(posedge clock) begin
        if (!n_rst) begin
            dcnt     <= '0;
            div_flag <= 1'b0;
            div_q    <= '0;
            div_r    <= '0;
        end else if (div_en) begin
            div_flag <= 1'b0;
            dcnt     <= 4'(BW + 1);
        end else if (dcnt != '0) begin
            dcnt <= dcnt - 4'd1;
            if (dcnt == 4'd1) begin
                div_flag       <= 1'b1;
                {div_q, div_r} <= div_model(div_a, div_b);
            end
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    int rise_q[$];
    int den_cnt = 0;
    logic den_prev = 1'b0;
    logic ov_prev = 1'b0;
    logic stalled = 1'b0;
    logic [EW-1:0] snap;
    logic [EW-1:0] cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (n_rst === 1'b1) begin
            cur = {out_q, out_r, out_tag, out_dz};
            if (div_en === 1'b1) begin
                den_cnt++;
                check("div_en_single_cycle", 64'(den_prev), 64'd0);
            end
            den_prev = div_en;
            if (out_valid === 1'b1 && ov_prev === 1'b0) rise_q.push_back(cyc);
            ov_prev = out_valid;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected no result", cur);
                end else begin
                    check("result", 64'(cur), 64'(exp_q.pop_front()));
                end
                stalled = 1'b0;
            end else if (out_valid === 1'b1) begin
                if (stalled) check("stall_stable", 64'(cur), 64'(snap));
                snap    = cur;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end else begin
            den_prev = 1'b0;
            ov_prev  = 1'b0;
            stalled  = 1'b0;
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [TW-1:0] tag,
                        output int acc, output int waited);
        logic rdy;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        waited   = 0;
        forever begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no acceptance expected acceptance of tag %0d", tag);
                break;
            end
        end
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0)) begin
            @(posedge clock);
            #1;
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [TW-1:0] tag;
        logic [BW:0]   q;
        logic [BW-1:0] r;
        logic          dz;
    } vec_t;

    vec_t vecs[9];
    vec_t burst[6];
    vec_t quad[4];

    initial begin
        int acc, waited;

        vecs[0] = '{a: 8'(-100), b: 8'd7,     tag: 4'd1, q: 9'(-14), r: 8'(-2),   dz: 1'b0};
        vecs[1] = '{a: 8'd100,   b: 8'(-7),   tag: 4'd2, q: 9'(-14), r: 8'd2,     dz: 1'b0};
        vecs[2] = '{a: 8'(-100), b: 8'(-7),   tag: 4'd3, q: 9'd14,   r: 8'(-2),   dz: 1'b0};
        vecs[3] = '{a: 8'd55,    b: 8'd0,     tag: 4'd4, q: 9'd0,    r: 8'd55,    dz: 1'b1};
        vecs[4] = '{a: 8'd9,     b: 8'd3,     tag: 4'd5, q: 9'd3,    r: 8'd0,     dz: 1'b0};
        vecs[5] = '{a: 8'(-128), b: 8'(-1),   tag: 4'd6, q: 9'd128,  r: 8'd0,     dz: 1'b0};
        vecs[6] = '{a: 8'(-128), b: 8'd0,     tag: 4'd7, q: 9'd0,    r: 8'(-128), dz: 1'b1};
        vecs[7] = '{a: 8'd127,   b: 8'd127,   tag: 4'd8, q: 9'd1,    r: 8'd0,     dz: 1'b0};
        vecs[8] = '{a: 8'(-7),   b: 8'd100,   tag: 4'd9, q: 9'd0,    r: 8'(-7),   dz: 1'b0};

        burst[0] = '{a: 8'd10, b: 8'd3, tag: 4'd0, q: 9'd3, r: 8'd1, dz: 1'b0};
        burst[1] = '{a: 8'd13, b: 8'd3, tag: 4'd1, q: 9'd4, r: 8'd1, dz: 1'b0};
        burst[2] = '{a: 8'd16, b: 8'd3, tag: 4'd2, q: 9'd5, r: 8'd1, dz: 1'b0};
        burst[3] = '{a: 8'd19, b: 8'd3, tag: 4'd3, q: 9'd6, r: 8'd1, dz: 1'b0};
        burst[4] = '{a: 8'd22, b: 8'd3, tag: 4'd4, q: 9'd7, r: 8'd1, dz: 1'b0};
        burst[5] = '{a: 8'd25, b: 8'd3, tag: 4'd5, q: 9'd8, r: 8'd1, dz: 1'b0};

        quad[0] = '{a: 8'd40,   b: 8'd5,    tag: 4'hA, q: 9'd8,    r: 8'd0,   dz: 1'b0};
        quad[1] = '{a: 8'(-40), b: 8'd3,    tag: 4'hB, q: 9'(-13), r: 8'(-1), dz: 1'b0};
        quad[2] = '{a: 8'd7,    b: 8'(-2),  tag: 4'hC, q: 9'(-3),  r: 8'd1,   dz: 1'b0};
        quad[3] = '{a: 8'd0,    b: 8'd9,    tag: 4'hD, q: 9'd0,    r: 8'd0,   dz: 1'b0};

        n_rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_div_en",    64'(div_en), 64'd0);
        check("rst_div_ab",    64'({div_a, div_b}), 64'd0);
        check("rst_out_bus",   64'({out_q, out_r, out_tag, out_dz}), 64'd0);
        check("rst_state",     64'(fsm_state), 64'd0);
        @(posedge clock);
        #1 n_rst = 1'b1;
        @(posedge clock);
        #1 check("release_in_ready", 64'(in_ready), 64'd1);

        // single request latency
        rise_q.delete();
        exp_q.push_back({9'd14, 8'd2, 4'd3, 1'b0});
        send(8'd100, 8'd7, 4'd3, acc, waited);
        wait_drain(100);
        check("latency_one_rise", 64'(rise_q.size()), 64'd1);
        if (rise_q.size() > 0) check("latency_cycles", 64'(rise_q[0] - acc), 64'd12);

        // table vectors, out_ready held high
        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].dz});
            send(vecs[i].a, vecs[i].b, vecs[i].tag, acc, waited);
        end
        wait_drain(400);

        // capacity: five accepted while stalled, sixth held off
        out_ready = 1'b0;
        foreach (burst[i]) exp_q.push_back({burst[i].q, burst[i].r, burst[i].tag, burst[i].dz});
        for (int i = 0; i < 5; i++) begin
            send(burst[i].a, burst[i].b, burst[i].tag, acc, waited);
            check("burst_accept_wait", 64'(waited), 64'd0);
        end
        in_valid = 1'b1; in_a = burst[5].a; in_b = burst[5].b; in_tag = burst[5].tag;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            check("full_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        send(burst[5].a, burst[5].b, burst[5].tag, acc, waited);
        wait_drain(400);

        // reset mid-WAIT discards in-flight and queued work
        send(8'd50, 8'd5, 4'd6, acc, waited);
        send(8'd60, 8'd6, 4'd7, acc, waited);
        repeat (4) @(posedge clock);
        #1 check("pre_reset_state_wait", 64'(fsm_state), 64'd2);
        n_rst = 1'b0;
        @(posedge clock);
        #1 n_rst = 1'b1;
        @(negedge clock);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        check("post_reset_busy",      64'(busy), 64'd0);
        check("post_reset_in_ready",  64'(in_ready), 64'd1);
        repeat (30) @(posedge clock);
        #1 check("post_reset_quiet", 64'(out_valid), 64'd0);
        exp_q.push_back({9'd3, 8'd2, 4'd8, 1'b0});
        send(8'd20, 8'd6, 4'd8, acc, waited);
        wait_drain(100);

        // throughput: four back-to-back requests
        rise_q.delete();
        den_cnt = 0;
        foreach (quad[i]) exp_q.push_back({quad[i].q, quad[i].r, quad[i].tag, quad[i].dz});
        foreach (quad[i]) send(quad[i].a, quad[i].b, quad[i].tag, acc, waited);
        wait_drain(200);
        check("thru_pulses", 64'(rise_q.size()), 64'd4);
        for (int i = 1; i < rise_q.size(); i++) check("thru_spacing", 64'(rise_q[i] - rise_q[i-1]), 64'd12);
        check("thru_div_en_count", 64'(den_cnt), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
